// File: rtl/resp_sched.sv
// resp_sched: round-robin scheduler that shares one UART/BLE transmit path
// between several byte requesters, with a tx_done watchdog.
module resp_sched #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 32768,
  parameter int TW      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] byte_in,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        resp,
  output logic              trmt,
  input  logic              tx_done,
  output logic              busy,
  output logic [NREQ-1:0]   ovf,
  output logic              tmo,
  input  logic              clr_err
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [NREQ-1:0] pend;
  logic [7:0]      data [NREQ];
  logic [PW-1:0]   rr_ptr;
  logic [TW-1:0]   cnt;
  logic [PW-1:0]   win;
  logic [NREQ-1:0] win_oh;
  logic            launch;
  logic            expire;
  int              j;

  // Scan from farthest to nearest so the first set bit after rr_ptr wins.
  always_comb begin
    win    = '0;
    launch = 1'b0;
    win_oh = '0;
    j      = 0;
    for (int k = NREQ; k >= 1; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (pend[PW'(j)]) begin
        win    = PW'(j);
        launch = 1'b1;
      end
    end
    if (state != IDLE) launch = 1'b0;
    if (launch) win_oh[win] = 1'b1;
  end

  // A tx_done in the final watchdog cycle still counts as a clean finish.
  assign expire = (state == WAIT) && !tx_done
               && (cnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|pend) state_nxt = SEND;
      SEND:    state_nxt = WAIT;
      WAIT:    if (tx_done || expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SEND) || (state == WAIT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend   <= '0;
      rr_ptr <= PW'(NREQ - 1);
      resp   <= '0;
      trmt   <= 1'b0;
      gnt    <= '0;
      cnt    <= '0;
      ovf    <= '0;
      tmo    <= 1'b0;
      for (int i = 0; i < NREQ; i++) data[i] <= '0;
    end else begin
      trmt <= launch;
      gnt  <= win_oh;
      if (launch) begin
        resp   <= data[win];
        rr_ptr <= win;
      end
      if (state == SEND)      cnt <= '0;
      else if (state == WAIT) cnt <= cnt + TW'(1);
      // A re-request on the granted slot refills it with the new byte.
      pend <= (pend & ~win_oh) | req;
      for (int i = 0; i < NREQ; i++)
        if (req[i]) data[i] <= byte_in[8*i +: 8];
      ovf <= (ovf & {NREQ{~clr_err}}) | (req & pend & ~win_oh);
      tmo <= (tmo & ~clr_err) | expire;
    end
  end

endmodule

// File: tb/tb_resp_sched.sv
// tb_resp_sched: directed stimulus against a transaction-level model
// of the response scheduler plus literal launch-order expectations.
module tb_resp_sched;

  localparam int NREQ = 3;
  localparam int TMO  = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] byte_in;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        resp;
  logic              trmt;
  logic              tx_done;
  logic              busy;
  logic [NREQ-1:0]   ovf;
  logic              tmo;
  logic              clr_err;
  logic              auto_pulse;
  logic              man_pulse;

  assign tx_done = auto_pulse | man_pulse;

  resp_sched #(.NREQ(NREQ), .TIMEOUT(TMO), .TW(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .byte_in (byte_in),
    .gnt     (gnt),
    .resp    (resp),
    .trmt    (trmt),
    .tx_done (tx_done),
    .busy    (busy),
    .ovf     (ovf),
    .tmo     (tmo),
    .clr_err (clr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit armed  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // wrapper stand-in: answers each trmt with tx_done after done_dly cycles
  bit auto_en = 0;
  int done_dly = 20;
  initial begin
    auto_pulse = 1'b0;
    forever begin
      @(negedge clk);
      if (trmt && auto_en) begin
        repeat (done_dly) @(posedge clk);
        #1 auto_pulse = 1'b1;
        @(posedge clk);
        #1 auto_pulse = 1'b0;
      end
    end
  end

  // transaction-level model of the scheduler
  bit [NREQ-1:0] m_pend;
  logic [7:0]    m_data [NREQ];
  int            m_last;
  int            m_phase;   // 0 idle, 1 launching, 2 awaiting done
  int            m_wait;
  logic [7:0]    m_resp;
  logic          m_trmt;
  logic [NREQ-1:0] m_gnt;
  logic [NREQ-1:0] m_ovf;
  logic          m_tmo;

  always @(posedge clk) begin : mdl
    int  w;
    bit  go;
    int  ph;
    if (rst) begin
      m_pend = '0; m_last = NREQ - 1; m_phase = 0; m_wait = 0;
      m_resp = 8'h00; m_trmt = 1'b0; m_gnt = '0; m_ovf = '0; m_tmo = 1'b0;
      for (int i = 0; i < NREQ; i++) m_data[i] = 8'h00;
    end else begin
      ph = m_phase; go = 0; w = 0;
      m_trmt = 1'b0; m_gnt = '0;
      if (clr_err) begin m_ovf = '0; m_tmo = 1'b0; end
      if (ph == 0 && m_pend != 0) begin
        for (int k = 1; k <= NREQ; k++)
          if (!go && m_pend[(m_last + k) % NREQ]) begin
            w = (m_last + k) % NREQ; go = 1;
          end
        m_resp = m_data[w]; m_pend[w] = 1'b0; m_last = w;
        m_trmt = 1'b1; m_gnt[w] = 1'b1; m_phase = 1;
      end else if (ph == 1) begin
        m_phase = 2; m_wait = 0;
      end else if (ph == 2) begin
        if (tx_done) m_phase = 0;
        else if (m_wait == TMO - 1) begin m_tmo = 1'b1; m_phase = 0; end
        else m_wait++;
      end
      for (int i = 0; i < NREQ; i++)
        if (req[i]) begin
          if (m_pend[i]) m_ovf[i] = 1'b1;
          m_pend[i] = 1'b1;
          m_data[i] = byte_in[8*i +: 8];
        end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if ({trmt, resp, gnt, busy, ovf, tmo} !==
          {m_trmt, m_resp, m_gnt, (m_phase != 0), m_ovf, m_tmo}) begin
        errors++;
        $display("FAIL model cyc=%0d dut trmt=%b resp=%h gnt=%b busy=%b ovf=%b tmo=%b exp trmt=%b resp=%h gnt=%b busy=%b ovf=%b tmo=%b",
                 cyc, trmt, resp, gnt, busy, ovf, tmo,
                 m_trmt, m_resp, m_gnt, (m_phase != 0), m_ovf, m_tmo);
      end
    end
  end

  // launch log taken from the DUT outputs
  logic [7:0]      sent_q   [$];
  int              sent_cyc [$];
  logic [NREQ-1:0] sent_gnt [$];
  int              fall_cyc = 0;
  bit              prev_busy = 0;

  always @(negedge clk) begin
    if (trmt) begin
      sent_q.push_back(resp);
      sent_cyc.push_back(cyc);
      sent_gnt.push_back(gnt);
    end
    if (prev_busy && !busy) fall_cyc = cyc;
    prev_busy = busy;
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(int t);
    while (cyc < t) tick();
  endtask

  task automatic send(logic [NREQ-1:0] m, logic [7:0] b0, logic [7:0] b1,
                      logic [7:0] b2);
    req = m;
    byte_in = {b2, b1, b0};
    tick();
    req = '0;
  endtask

  task automatic wait_sent(int n, int budget, string nm);
    int t = 0;
    while (sent_q.size() < n && t < budget) begin tick(); t++; end
    if (sent_q.size() < n) begin
      checks++; errors++;
      $display("FAIL %s: launches got %0d expected %0d", nm, sent_q.size(), n);
    end
  endtask

  task automatic wait_idle(int budget, string nm);
    int t = 0;
    while (busy && t < budget) begin tick(); t++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL %s: busy got 1 expected 0 within %0d cycles", nm, budget);
    end
    tick(2);
  endtask

  initial begin : script
    int base;
    int c;
    int s;
    int n;
    rst = 1'b1; req = '0; byte_in = '0; clr_err = 1'b0; man_pulse = 1'b0;
    tick(2);
    armed = 1;
    chk("reset_outputs", {resp, trmt, gnt, busy, ovf, tmo}, 0);
    rst = 1'b0;
    tick(2);

    // single request
    auto_en = 1; done_dly = 20;
    base = sent_q.size(); c = cyc;
    send(3'b001, 8'hA5, 8'h00, 8'h00);
    wait_sent(base + 1, 10, "single_launch");
    wait_idle(60, "single_idle");
    chk("single_byte", sent_q[base], 8'hA5);
    chk("single_gnt", sent_gnt[base], 3'b001);
    chk("single_trmt_cyc", sent_cyc[base] - c, 2);
    chk("single_busy_fall", fall_cyc - sent_cyc[base], 21);
    chk("single_count", sent_q.size(), base + 1);

    // simultaneous requests from reset
    rst = 1'b1; tick(); rst = 1'b0;
    done_dly = 5;
    base = sent_q.size();
    send(3'b111, 8'h11, 8'h22, 8'h33);
    wait_sent(base + 3, 100, "rr1_launch");
    wait_idle(40, "rr1_idle");
    chk("rr1_order", {sent_q[base], sent_q[base+1], sent_q[base+2]}, 24'h112233);
    base = sent_q.size();
    send(3'b111, 8'h11, 8'h22, 8'h33);
    wait_sent(base + 3, 100, "rr2_launch");
    wait_idle(40, "rr2_idle");
    chk("rr2_order", {sent_q[base], sent_q[base+1], sent_q[base+2]}, 24'h112233);
    base = sent_q.size();
    send(3'b101, 8'h11, 8'h00, 8'h33);
    wait_sent(base + 2, 100, "rr3_launch");
    wait_idle(40, "rr3_idle");
    chk("rr3_order", {sent_q[base], sent_q[base+1]}, 16'h1133);

    // overwrite while pending
    done_dly = 20;
    base = sent_q.size(); c = cyc;
    send(3'b001, 8'h10, 8'h00, 8'h00);
    goto(c + 4);
    send(3'b010, 8'h00, 8'h5A, 8'h00);
    goto(c + 6);
    send(3'b010, 8'h00, 8'h77, 8'h00);
    wait_sent(base + 2, 200, "ovw_launch");
    wait_idle(60, "ovw_idle");
    chk("ovw_order", {sent_q[base], sent_q[base+1]}, 16'h1077);
    chk("ovw_count", sent_q.size(), base + 2);
    chk("ovw_ovf", ovf, 3'b010);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("ovw_clr", ovf, 0);

    // re-request in the grant cycle
    base = sent_q.size();
    send(3'b100, 8'h00, 8'h00, 8'h33);
    send(3'b100, 8'h00, 8'h00, 8'h44);
    wait_sent(base + 2, 200, "rereq_launch");
    wait_idle(60, "rereq_idle");
    chk("rereq_order", {sent_q[base], sent_q[base+1]}, 16'h3344);
    chk("rereq_ovf", ovf, 0);

    // watchdog
    auto_en = 0;
    base = sent_q.size(); c = cyc; s = c + 2;
    send(3'b001, 8'hE1, 8'h00, 8'h00);
    goto(c + 5);
    send(3'b010, 8'h00, 8'hE2, 8'h00);
    wait_idle(300, "wd_idle1");
    chk("wd_fall", fall_cyc - s, 101);
    chk("wd_tmo", tmo, 1);
    wait_sent(base + 2, 20, "wd_next_launch");
    chk("wd_next_byte", sent_q[base+1], 8'hE2);
    chk("wd_next_cyc", sent_cyc[base+1] - s, 102);
    wait_idle(300, "wd_idle2");
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("wd_clr", tmo, 0);
    base = sent_q.size(); c = cyc; s = c + 2;
    send(3'b001, 8'hE3, 8'h00, 8'h00);
    goto(s + 100);
    man_pulse = 1'b1; tick(); man_pulse = 1'b0;
    tick(3);
    chk("wd_race_tmo", tmo, 0);
    chk("wd_race_fall", fall_cyc - s, 101);
    chk("wd_race_byte", sent_q[base], 8'hE3);

    // reset mid-wait with two bytes pending
    base = sent_q.size();
    send(3'b001, 8'h55, 8'h00, 8'h00);
    tick(3);
    send(3'b110, 8'h00, 8'h66, 8'h77);
    tick(2);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_outputs", {resp, trmt, gnt, busy, ovf, tmo}, 0);
    n = sent_q.size();
    tick(10);
    man_pulse = 1'b1; tick(); man_pulse = 1'b0;
    tick(30);
    chk("rst_no_launch", sent_q.size(), n);
    chk("rst_one_sent", n, base + 1);
    chk("rst_idle", {busy, tmo, ovf}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/resp_sched.md
Name: resp_sched

Overview:
- Schedules the single UART/BLE transmit path so several on-board requesters can share it.
- Requesters include command-completion acks (0xA5/0x5A), tour-progress bytes and calibration status.
- Latches one pending byte per requester and grants the transmitter round-robin.
- Drives the wrapper's trmt/resp pair and waits for tx_done before granting again. A watchdog recovers from a lost tx_done.

Parameters:
- NREQ, 3: number of requester ports (2..8).
- TIMEOUT, 32768: clk cycles to wait for tx_done before abort. One byte at 19200 baud is about 26042 cycles at 50 MHz.
- TW, 16: timeout counter width; must satisfy TIMEOUT < 2^TW.

Ports:
- clk  in  1  system clock; the single clock of the block.
- rst  in  1  reset, synchronous, active-high.
- req  in  NREQ  per-requester one-cycle send request.
- byte_in  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i]; sampled when req[i]=1.
- gnt  out  NREQ  one-hot, one-cycle pulse when requester i's byte is launched.
- resp  out  8  byte to UART wrapper.
- trmt  out  1  one-cycle transmit strobe to UART wrapper.
- tx_done  in  1  wrapper byte-complete pulse.
- busy  out  1  high in SEND or WAIT.
- ovf  out  NREQ  sticky: request arrived while the same requester was still pending.
- tmo  out  1  sticky: watchdog expired.
- clr_err  in  1  clears ovf and tmo.

Behaviour:
- Everything is synchronous to clk.
- On rst=1 at an edge:
  - state=IDLE; pend=0; data regs=0; rr_ptr=NREQ-1.
  - resp=0x00, trmt=0, gnt=0, busy=0, ovf=0, tmo=0; timeout counter=0.
- Pending latch, per requester i:
  - req[i]=1 sets pend[i] and loads data[i]=byte_in[i] at the next edge.
  - If pend[i] is already 1 and not being granted that cycle: data[i] is overwritten (latest wins) and ovf[i] is set.
  - If req[i] coincides with grant of i: the granted (old) byte is sent, and pend[i] stays 1 holding the new byte. No ovf.
- Arbitration, evaluated only in IDLE with |pend:
  - Winner w is the first set pend bit searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - At that edge: resp<=data[w], pend[w] cleared (unless the re-request rule applies), rr_ptr<=w.
  - Also at that edge: gnt[w]<=1, trmt<=1, state<=SEND.
- FSM:
  - IDLE: wait for |pend.
  - SEND: single cycle; trmt and gnt are high in this cycle only. Counter cleared. Next state WAIT.
  - WAIT:
    - Counter increments each cycle.
    - tx_done=1 -> IDLE.
    - Counter reaching TIMEOUT-1 without tx_done -> tmo<=1 -> IDLE. The aborted byte is dropped, not retried.
- Latency:
  - req at edge k is latched at edge k+1.
  - If the block was IDLE with no other pend, the grant registers at edge k+2: trmt is high in the cycle after that edge.
  - Back-to-back: after tx_done, IDLE lasts at least one cycle, so at least one idle cycle separates consecutive trmt pulses.
- tx_done handling:
  - tx_done in IDLE or SEND is ignored.
  - tx_done and timeout in the same cycle -> treated as done, tmo not set.
- resp holds its value until the next grant, so the wrapper may sample it at any point in SEND/WAIT.
- clr_err:
  - Clears ovf/tmo at the edge.
  - If a set condition occurs in the same cycle, set wins.
- rst mid-transfer:
  - Immediate return to IDLE; all pending bytes discarded.
  - trmt is not reissued.
  - A tx_done arriving afterwards is ignored.
- busy is a combinational decode of state (SEND or WAIT).

Test Plan:
- Single request: req[0] with 0xA5, tx_done 20 cycles after trmt. Required:
  - trmt high exactly one cycle, 2 cycles after the req cycle.
  - resp=0xA5, gnt=3'b001 in the same cycle.
  - busy drops the cycle after tx_done.
- Simultaneous requests: req=3'b111 with bytes 0x11/0x22/0x33 from reset. Required:
  - Transmit order 0x11, 0x22, 0x33.
  - A second round of 3'b111 also sends 0x11, 0x22, 0x33.
  - Then req=3'b101 sends 0x11, 0x33.
- Overwrite: req[1]=0x5A while WAIT for another requester, then req[1]=0x77 two cycles later. Required: only 0x77 sent for requester 1; ovf=3'b010 until clr_err pulse.
- Re-request during grant: req[2] with 0x44 pulsed in the same cycle requester 2's 0x33 is granted. Required: 0x33 then 0x44 transmitted, ovf stays 0.
- Watchdog: TIMEOUT=100, never assert tx_done. Required:
  - Return to IDLE 101 cycles after the SEND cycle; tmo=1.
  - The next pending byte launches normally.
  - tx_done in the same cycle as expiry gives tmo=0.
- Reset mid-WAIT with 2 bytes pending: rst for one cycle. Required: all outputs 0; no further trmt; a late tx_done has no effect.
